instruction_fetch_unit: RTL and testbench

Instruction fetch stage of the single-cycle RISC-V core. Holds the 32-bit program counter (PC) and a preloaded, read-only, byte-organised instruction memory, and presents the instruction word at the current PC on `OUTPUT`. It advances sequentially by 4 bytes each clock; branch and jump redirection are outside this block.

---
 rtl/instruction_fetch_unit.sv | 74 +++++++
 tb/tb_instruction_fetch_unit.sv | 118 +++++++++++
 2 files changed

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: 32-bit PC plus preloaded little-endian byte ROM; OUTPUT is the instruction at the PC.
// Zero-cycle latency from PC to OUTPUT; no backpressure, the PC advances by 4 on every clock.
module instruction_fetch_unit #(
   parameter int MEM_BYTES = 256
) (
   input  logic        CLOCK,
   input  logic        RESET,
   output logic [31:0] OUTPUT
);

   localparam int IDX_W = $clog2(MEM_BYTES);

   generate
      if ((MEM_BYTES < 4) || ((MEM_BYTES & (MEM_BYTES - 1)) != 0)) begin : g_bad_size
         $error("MEM_BYTES must be a power of two and at least 4");
      end
   endgenerate

   logic [31:0]      pc_q;
   logic [31:0]      pc_d;
   logic [IDX_W-1:0] idx0;
   logic [IDX_W-1:0] idx1;
   logic [IDX_W-1:0] idx2;
   logic [IDX_W-1:0] idx3;

   // Constant ROM: program occupies the first 32 bytes, everything else reads as zero.
   function automatic logic [7:0] rom_byte(input logic [IDX_W-1:0] addr);
      logic [31:0] a;
      logic [31:0] w;
      logic [7:0]  b;
      a = 32'(addr);
      w = 32'h0000_0000;
      if (a[31:5] == 27'd0) begin
         case (a[4:2])
            3'd0:    w = 32'h0050_0093;
            3'd1:    w = 32'h00A0_0113;
            3'd2:    w = 32'h0020_81B3;
            3'd3:    w = 32'h4011_0233;
            3'd4:    w = 32'h0020_F2B3;
            3'd5:    w = 32'h0020_E333;
            3'd6:    w = 32'h0020_C3B3;
            default: w = 32'h0020_9433;
         endcase
      end
      case (a[1:0])
         2'd0:    b = w[7:0];
         2'd1:    b = w[15:8];
         2'd2:    b = w[23:16];
         default: b = w[31:24];
      endcase
      return b;
   endfunction

   always_comb begin
      pc_d = pc_q + 32'd4;
   end

   always_ff @(posedge CLOCK or posedge RESET) begin
      if (RESET) begin
         pc_q <= 32'h0000_0000;
      end else begin
         pc_q <= pc_d;
      end
   end

   always_comb begin
      idx0   = pc_q[IDX_W-1:0];
      idx1   = idx0 + IDX_W'(1);
      idx2   = idx0 + IDX_W'(2);
      idx3   = idx0 + IDX_W'(3);
      OUTPUT = {rom_byte(idx3), rom_byte(idx2), rom_byte(idx1), rom_byte(idx0)};
   end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit with a queue scoreboard of expected fetch words.
module tb_instruction_fetch_unit;

   logic        CLOCK;
   logic        RESET;
   logic [31:0] OUTPUT;

   int total;
   int bad;
   logic [31:0] sb_q[$];
   logic [31:0] prog[8];

   instruction_fetch_unit #(.MEM_BYTES(256)) dut (
      .CLOCK  (CLOCK),
      .RESET  (RESET),
      .OUTPUT (OUTPUT)
   );

   initial CLOCK = 1'b0;
   always #5 CLOCK = ~CLOCK;

   // Expected word after k edges out of reset, with 64-word wrap.
   function automatic logic [31:0] word_after(input int k);
      int w;
      w = k % 64;
      return (w < 8) ? prog[w] : 32'h0000_0000;
   endfunction

   task automatic check(input string tag);
      logic [31:0] e;
      total++;
      if (sb_q.size() == 0) begin
         bad++;
         $error("FAIL %s scoreboard empty got=%h", tag, OUTPUT);
      end else begin
         e = sb_q.pop_front();
         assert (OUTPUT === e) else begin
            bad++;
            $error("FAIL %s got=%h expected=%h", tag, OUTPUT, e);
         end
      end
   endtask

   initial begin
      total = 0;
      bad   = 0;
      prog[0] = 32'h0050_0093;
      prog[1] = 32'h00A0_0113;
      prog[2] = 32'h0020_81B3;
      prog[3] = 32'h4011_0233;
      prog[4] = 32'h0020_F2B3;
      prog[5] = 32'h0020_E333;
      prog[6] = 32'h0020_C3B3;
      prog[7] = 32'h0020_9433;

      // Reset hold across three clock edges
      RESET = 1'b1;
      sb_q.push_back(32'h0050_0093);
      #1 check("reset_state");
      for (int i = 0; i < 3; i++) begin
         sb_q.push_back(32'h0050_0093);
         @(posedge CLOCK);
         #1 check("reset_hold");
      end

      // Release, then sequential fetch, zero region and wrap (65 edges)
      @(negedge CLOCK);
      RESET = 1'b0;
      sb_q.push_back(32'h0050_0093);
      #1 check("release_pre_edge");
      for (int k = 1; k <= 65; k++) begin
         sb_q.push_back(word_after(k));
         @(posedge CLOCK);
         #1;
         if (k <= 7)       check("seq_fetch");
         else if (k <= 63) check("zero_region");
         else              check("wrap");
      end

      // Advance to the sub instruction, then assert reset mid-cycle
      for (int k = 66; k <= 67; k++) begin
         sb_q.push_back(word_after(k));
         @(posedge CLOCK);
         #1 check("pre_async");
      end
      @(negedge CLOCK);
      #2 RESET = 1'b1;
      sb_q.push_back(32'h0050_0093);
      #1 check("async_reset");
      sb_q.push_back(32'h0050_0093);
      @(posedge CLOCK);
      #1 check("reset_priority_edge");

      // Release just after a rising edge
      RESET = 1'b0;
      sb_q.push_back(32'h0050_0093);
      #1 check("release_align_now");
      sb_q.push_back(32'h0050_0093);
      @(negedge CLOCK);
      #1 check("release_align_mid");
      sb_q.push_back(32'h00A0_0113);
      @(posedge CLOCK);
      #1 check("release_align_edge");
      sb_q.push_back(32'h0020_81B3);
      @(posedge CLOCK);
      #1 check("release_align_next");

      total++;
      assert (sb_q.size() == 0) else begin
         bad++;
         $error("FAIL scoreboard_drain got=%0d expected=0", sb_q.size());
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
